// File: rtl/shift_seq_arbiter_if.sv
// Request/grant/result bundle for shift_seq_arbiter.
// Optional macro: SHIFT_SEQ_ABORT_EN adds Abort/Aborted.
interface shift_seq_arbiter_if #(
   parameter int STEP_W = 4
);
   logic              Req0;
   logic              Req1;
   logic [2:0]        Seed0;
   logic [2:0]        Seed1;
   logic              A0;
   logic              A1;
   logic [STEP_W-1:0] Steps0;
   logic [STEP_W-1:0] Steps1;
   logic              Gnt0;
   logic              Gnt1;
   logic              Busy;
   logic              Done;
   logic              DoneId;
   logic [2:0]        Result;
   logic [STEP_W-1:0] ZCount;
`ifdef SHIFT_SEQ_ABORT_EN
   logic              Abort;
   logic              Aborted;

   modport slave (
      input  Req0, Req1, Seed0, Seed1,
      input  A0, A1, Steps0, Steps1, Abort,
      output Gnt0, Gnt1, Busy, Done,
      output DoneId, Result, ZCount, Aborted
   );
   modport master (
      output Req0, Req1, Seed0, Seed1,
      output A0, A1, Steps0, Steps1, Abort,
      input  Gnt0, Gnt1, Busy, Done,
      input  DoneId, Result, ZCount, Aborted
   );
`else
   modport slave (
      input  Req0, Req1, Seed0, Seed1,
      input  A0, A1, Steps0, Steps1,
      output Gnt0, Gnt1, Busy, Done,
      output DoneId, Result, ZCount
   );
   modport master (
      output Req0, Req1, Seed0, Seed1,
      output A0, A1, Steps0, Steps1,
      input  Gnt0, Gnt1, Busy, Done,
      input  DoneId, Result, ZCount
   );
`endif
endinterface

// File: rtl/shift_seq_arbiter.sv
// Two-requester round-robin arbiter around a 3-bit shift-sequence datapath.
// Optional macro: SHIFT_SEQ_ABORT_EN enables mid-job Abort.
module shift_seq_arbiter #(
   parameter int STEP_W = 4
) (
   input  logic         Clk,
   input  logic         Rst_n,
   shift_seq_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [2:0]        q_q, q_d;
   logic              a_q, a_d;
   logic [STEP_W-1:0] cnt_q, cnt_d;
   logic [STEP_W-1:0] zcnt_q, zcnt_d;
   logic              gnt0_q, gnt0_d;
   logic              gnt1_q, gnt1_d;
   logic              id_q, id_d;
   logic              last_q, last_d;
   logic              abt_q, abt_d;

   logic              z;
   logic              win1;
   logic [STEP_W-1:0] steps_w;

   assign z = ~(q_q[2] | q_q[1])
            ^ (q_q[1] ^ q_q[0]);

   // On a tie the requester not served last wins
   assign win1 = bus.Req1
               & (~bus.Req0 | ~last_q);

   assign steps_w = win1 ? bus.Steps1
                         : bus.Steps0;

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q <= S_IDLE;
         q_q     <= 3'b000;
         a_q     <= 1'b0;
         cnt_q   <= '0;
         zcnt_q  <= '0;
         gnt0_q  <= 1'b0;
         gnt1_q  <= 1'b0;
         id_q    <= 1'b0;
         last_q  <= 1'b1;
         abt_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         q_q     <= q_d;
         a_q     <= a_d;
         cnt_q   <= cnt_d;
         zcnt_q  <= zcnt_d;
         gnt0_q  <= gnt0_d;
         gnt1_q  <= gnt1_d;
         id_q    <= id_d;
         last_q  <= last_d;
         abt_q   <= abt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      q_d     = q_q;
      a_d     = a_q;
      cnt_d   = cnt_q;
      zcnt_d  = zcnt_q;
      gnt0_d  = gnt0_q;
      gnt1_d  = gnt1_q;
      id_d    = id_q;
      last_d  = last_q;
      abt_d   = abt_q;
      unique case (state_q)
         S_IDLE: begin
            if (bus.Req0 | bus.Req1) begin
               q_d     = win1 ? bus.Seed1 : bus.Seed0;
               a_d     = win1 ? bus.A1 : bus.A0;
               cnt_d   = steps_w;
               zcnt_d  = '0;
               gnt0_d  = ~win1;
               gnt1_d  = win1;
               id_d    = win1;
               last_d  = win1;
               abt_d   = 1'b0;
               state_d = (steps_w != '0) ? S_RUN
                                         : S_DONE;
            end
         end
         S_RUN: begin
`ifdef SHIFT_SEQ_ABORT_EN
            if (bus.Abort) begin
               state_d = S_DONE;
               abt_d   = 1'b1;
            end else begin
`else
            begin
`endif
               q_d    = {a_q & z, q_q[2], q_q[1]};
               zcnt_d = zcnt_q
                      + {{(STEP_W-1){1'b0}}, z};
               cnt_d  = cnt_q - 1'b1;
               if (cnt_q == {{(STEP_W-1){1'b0}}, 1'b1})
                  state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            gnt0_d  = 1'b0;
            gnt1_d  = 1'b0;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign bus.Gnt0   = gnt0_q;
   assign bus.Gnt1   = gnt1_q;
   assign bus.Busy   = (state_q == S_RUN)
                     | (state_q == S_DONE);
   assign bus.Done   = (state_q == S_DONE);
   assign bus.DoneId = id_q;
   assign bus.Result = q_q;
   assign bus.ZCount = zcnt_q;
`ifdef SHIFT_SEQ_ABORT_EN
   assign bus.Aborted = abt_q
                      & (state_q == S_DONE);
`endif

endmodule

// File: tb/tb_shift_seq_arbiter.sv
// Scoreboard bench for shift_seq_arbiter.
// Define SHIFT_SEQ_ABORT_EN to also exercise Abort.
module tb_shift_seq_arbiter;

   localparam int SW = 4;

   typedef struct {
      bit       id;
      bit [2:0] res;
      bit [3:0] z;
      bit       ab;
   } exp_t;

   logic Clk;
   logic Rst_n;
   int   n_cmp;
   int   n_bad;
   exp_t sb[$];

   shift_seq_arbiter_if #(.STEP_W(SW)) bus ();

   shift_seq_arbiter #(.STEP_W(SW)) dut (
      .Clk   (Clk),
      .Rst_n (Rst_n),
      .bus   (bus)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic wait_done(
      input  int maxc,
      output int cyc
   );
      cyc = -1;
      for (int i = 1; i <= maxc; i++) begin
         @(negedge Clk);
         if (bus.Done === 1'b1) begin
            cyc = i;
            break;
         end
      end
   endtask

   task automatic test_reset;
      Rst_n = 1'b0;
      repeat (2) @(negedge Clk);
      n_cmp++;
      if ({bus.Gnt0, bus.Gnt1, bus.Busy,
           bus.Done, bus.DoneId, bus.Result,
           bus.ZCount} !== '0) begin
         n_bad++;
         $display("FAIL reset_outs got %b%b%b%b%b %b %h",
                  bus.Gnt0, bus.Gnt1, bus.Busy,
                  bus.Done, bus.DoneId,
                  bus.Result, bus.ZCount);
      end
      Rst_n = 1'b1;
      @(negedge Clk);
      n_cmp++;
      if (bus.Busy !== 1'b0 || bus.Done !== 1'b0) begin
         n_bad++;
         $display("FAIL idle_hold busy=%b done=%b want 0 0",
                  bus.Busy, bus.Done);
      end
   endtask

   task automatic test_basic;
      exp_t       e;
      int         cyc;
      logic [2:0] tr [3];
      tr[0] = 3'b100;
      tr[1] = 3'b010;
      tr[2] = 3'b101;
      @(negedge Clk);
      sb.push_back('{0, 3'b110, 4'd3, 0});
      bus.Req0   = 1'b1;
      bus.Seed0  = 3'b000;
      bus.A0     = 1'b1;
      bus.Steps0 = 4'd4;
      @(negedge Clk);
      n_cmp++;
      if ({bus.Gnt0, bus.Gnt1, bus.Busy} !== 3'b101) begin
         n_bad++;
         $display("FAIL basic_grant got %b%b%b want 101",
                  bus.Gnt0, bus.Gnt1, bus.Busy);
      end
      bus.Seed0  = 3'b111;
      bus.A0     = 1'b0;
      bus.Steps0 = 4'd1;
      for (int k = 0; k < 3; k++) begin
         @(negedge Clk);
         n_cmp++;
         if (bus.Result !== tr[k] || bus.Done !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_trace%0d got %b done=%b want %b",
                     k, bus.Result, bus.Done, tr[k]);
         end
      end
      wait_done(3, cyc);
      n_cmp++;
      if (cyc !== 1) begin
         n_bad++;
         $display("FAIL basic_latency got %0d want 1", cyc);
      end
      if (cyc > 0) begin
         e = sb.pop_front();
         n_cmp++;
         if ({bus.DoneId, bus.Result, bus.ZCount} !==
             {e.id, e.res, e.z}) begin
            n_bad++;
            $display("FAIL basic_result got %b %b %0d want %b %b %0d",
                     bus.DoneId, bus.Result, bus.ZCount,
                     e.id, e.res, e.z);
         end
      end
      bus.Req0 = 1'b0;
      @(negedge Clk);
      n_cmp++;
      if ({bus.Result, bus.ZCount, bus.Done,
           bus.Gnt0, bus.Busy} !== {3'b110, 4'd3, 3'b000}) begin
         n_bad++;
         $display("FAIL basic_hold got %b %0d %b%b%b want 110 3 000",
                  bus.Result, bus.ZCount, bus.Done,
                  bus.Gnt0, bus.Busy);
      end
   endtask

   task automatic test_req1;
      exp_t e;
      int   cyc;
      bit   g0;
      g0  = 0;
      cyc = -1;
      @(negedge Clk);
      sb.push_back('{1, 3'b000, 4'd2, 0});
      bus.Req1   = 1'b1;
      bus.Seed1  = 3'b000;
      bus.A1     = 1'b0;
      bus.Steps1 = 4'd2;
      for (int i = 1; i <= 5; i++) begin
         @(negedge Clk);
         if (bus.Gnt0 !== 1'b0) g0 = 1;
         if (bus.Done === 1'b1) begin
            cyc = i;
            break;
         end
      end
      n_cmp++;
      if (cyc !== 3 || g0) begin
         n_bad++;
         $display("FAIL req1_timing got cyc=%0d gnt0=%0d want 3 0",
                  cyc, g0);
      end
      if (cyc > 0) begin
         e = sb.pop_front();
         n_cmp++;
         if ({bus.DoneId, bus.Result, bus.ZCount} !==
             {e.id, e.res, e.z}) begin
            n_bad++;
            $display("FAIL req1_result got %b %b %0d want %b %b %0d",
                     bus.DoneId, bus.Result, bus.ZCount,
                     e.id, e.res, e.z);
         end
      end
      bus.Req1 = 1'b0;
   endtask

   task automatic test_steps_edge;
      exp_t       e;
      int         cyc;
      logic [3:0] st [2];
      logic [2:0] rs [2];
      int         lat [2];
      st[0] = 4'd0; rs[0] = 3'b111; lat[0] = 1;
      st[1] = 4'd1; rs[1] = 3'b011; lat[1] = 2;
      for (int j = 0; j < 2; j++) begin
         @(negedge Clk);
         sb.push_back('{0, rs[j], 4'd0, 0});
         bus.Req0   = 1'b1;
         bus.Seed0  = 3'b111;
         bus.A0     = 1'b1;
         bus.Steps0 = st[j];
         wait_done(4, cyc);
         n_cmp++;
         if (cyc !== lat[j] || bus.Gnt0 !== 1'b1) begin
            n_bad++;
            $display("FAIL steps%0d_latency got %0d gnt0=%b want %0d 1",
                     j, cyc, bus.Gnt0, lat[j]);
         end
         if (cyc > 0) begin
            e = sb.pop_front();
            n_cmp++;
            if ({bus.DoneId, bus.Result, bus.ZCount} !==
                {e.id, e.res, e.z}) begin
               n_bad++;
               $display("FAIL steps%0d_result got %b %b %0d want %b %b %0d",
                        j, bus.DoneId, bus.Result, bus.ZCount,
                        e.id, e.res, e.z);
            end
         end
         bus.Req0 = 1'b0;
      end
   endtask

   task automatic test_back_to_back;
      exp_t e;
      int   nd;
      bit   both;
      nd   = 0;
      both = 0;
      @(negedge Clk);
      Rst_n = 1'b0;
      @(negedge Clk);
      Rst_n = 1'b1;
      sb.push_back('{0, 3'b100, 4'd1, 0});
      sb.push_back('{1, 3'b011, 4'd0, 0});
      sb.push_back('{0, 3'b100, 4'd1, 0});
      bus.Seed0  = 3'b000;
      bus.A0     = 1'b1;
      bus.Steps0 = 4'd1;
      bus.Seed1  = 3'b111;
      bus.A1     = 1'b1;
      bus.Steps1 = 4'd1;
      bus.Req0   = 1'b1;
      bus.Req1   = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge Clk);
         if (bus.Gnt0 === 1'b1 && bus.Gnt1 === 1'b1)
            both = 1;
         if (bus.Done === 1'b1) begin
            e = sb.pop_front();
            nd++;
            n_cmp++;
            if ({bus.DoneId, bus.Result, bus.ZCount} !==
                {e.id, e.res, e.z}) begin
               n_bad++;
               $display("FAIL b2b_job%0d got %b %b %0d want %b %b %0d",
                        nd, bus.DoneId, bus.Result, bus.ZCount,
                        e.id, e.res, e.z);
            end
            if (nd == 3) break;
         end
      end
      bus.Req0 = 1'b0;
      bus.Req1 = 1'b0;
      n_cmp++;
      if (nd !== 3 || both) begin
         n_bad++;
         $display("FAIL b2b_order got jobs=%0d both=%0d want 3 0",
                  nd, both);
      end
      while (sb.size() > 0) void'(sb.pop_front());
   endtask

   task automatic test_reset_mid;
      exp_t e;
      int   cyc;
      @(negedge Clk);
      bus.Req0   = 1'b1;
      bus.Seed0  = 3'b000;
      bus.A0     = 1'b1;
      bus.Steps0 = 4'd4;
      repeat (3) @(negedge Clk);
      n_cmp++;
      if (bus.Result !== 3'b010) begin
         n_bad++;
         $display("FAIL rstmid_pre got %b want 010", bus.Result);
      end
      Rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({bus.Gnt0, bus.Busy, bus.Done,
           bus.Result} !== 6'b0) begin
         n_bad++;
         $display("FAIL rstmid_clear got %b%b%b %b want 000 000",
                  bus.Gnt0, bus.Busy, bus.Done, bus.Result);
      end
      bus.Req0 = 1'b0;
      @(negedge Clk);
      Rst_n = 1'b1;
      sb.push_back('{1, 3'b000, 4'd2, 0});
      bus.Req1   = 1'b1;
      bus.Seed1  = 3'b000;
      bus.A1     = 1'b0;
      bus.Steps1 = 4'd2;
      wait_done(5, cyc);
      n_cmp++;
      if (cyc !== 3) begin
         n_bad++;
         $display("FAIL rstmid_latency got %0d want 3", cyc);
      end
      if (cyc > 0) begin
         e = sb.pop_front();
         n_cmp++;
         if ({bus.DoneId, bus.Result, bus.ZCount} !==
             {e.id, e.res, e.z}) begin
            n_bad++;
            $display("FAIL rstmid_result got %b %b %0d want %b %b %0d",
                     bus.DoneId, bus.Result, bus.ZCount,
                     e.id, e.res, e.z);
         end
      end
      bus.Req1 = 1'b0;
   endtask

`ifdef SHIFT_SEQ_ABORT_EN
   task automatic test_abort;
      exp_t e;
      int   cyc;
      @(negedge Clk);
      sb.push_back('{0, 3'b010, 4'd1, 1});
      bus.Req0   = 1'b1;
      bus.Seed0  = 3'b000;
      bus.A0     = 1'b1;
      bus.Steps0 = 4'd4;
      repeat (3) @(negedge Clk);
      bus.Abort = 1'b1;
      wait_done(1, cyc);
      bus.Abort = 1'b0;
      n_cmp++;
      if (cyc !== 1) begin
         n_bad++;
         $display("FAIL abort_timing got %0d want 1", cyc);
      end
      if (cyc > 0) begin
         e = sb.pop_front();
         n_cmp++;
         if ({bus.DoneId, bus.Result, bus.ZCount,
              bus.Aborted} !== {e.id, e.res, e.z, e.ab}) begin
            n_bad++;
            $display("FAIL abort_result got %b %b %0d %b want %b %b %0d %b",
                     bus.DoneId, bus.Result, bus.ZCount,
                     bus.Aborted, e.id, e.res, e.z, e.ab);
         end
      end
      bus.Req0 = 1'b0;
      @(negedge Clk);
      sb.push_back('{0, 3'b011, 4'd0, 0});
      bus.Req0   = 1'b1;
      bus.Seed0  = 3'b111;
      bus.Steps0 = 4'd1;
      bus.Abort  = 1'b1;
      @(negedge Clk);
      bus.Abort = 1'b0;
      wait_done(3, cyc);
      n_cmp++;
      if (cyc !== 1) begin
         n_bad++;
         $display("FAIL abort_idle_timing got %0d want 1", cyc);
      end
      if (cyc > 0) begin
         e = sb.pop_front();
         n_cmp++;
         if ({bus.Result, bus.ZCount, bus.Aborted} !==
             {e.res, e.z, e.ab}) begin
            n_bad++;
            $display("FAIL abort_idle got %b %0d %b want %b %0d %b",
                     bus.Result, bus.ZCount, bus.Aborted,
                     e.res, e.z, e.ab);
         end
      end
      bus.Req0 = 1'b0;
   endtask
`endif

   initial begin
      n_cmp      = 0;
      n_bad      = 0;
      Rst_n      = 1'b0;
      bus.Req0   = 1'b0;
      bus.Req1   = 1'b0;
      bus.Seed0  = 3'b000;
      bus.Seed1  = 3'b000;
      bus.A0     = 1'b0;
      bus.A1     = 1'b0;
      bus.Steps0 = '0;
      bus.Steps1 = '0;
`ifdef SHIFT_SEQ_ABORT_EN
      bus.Abort  = 1'b0;
`endif
      test_reset();
      test_basic();
      test_req1();
      test_steps_edge();
      test_back_to_back();
      test_reset_mid();
`ifdef SHIFT_SEQ_ABORT_EN
      test_abort();
`endif
      n_cmp++;
      if (sb.size() !== 0) begin
         n_bad++;
         $display("FAIL sb_leftover got %0d want 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/shift_seq_arbiter.md
Name: shift_seq_arbiter

Overview:
- Shares one 3-bit feedback shift-sequence datapath between two requesters and sequences each job on it.
- Datapath: Q2/Q1/Q0 registers; Z = NOR(Q2,Q1) XOR (Q1 XOR Q0); per step Q2<=A&Z, Q1<=Q2, Q0<=Q1.
- Per job: round-robin grant, seed load, run a requested number of steps, count Z=1 cycles, return the final state with a one-cycle Done pulse.
- Sits between sequence-test clients and the shared sequence datapath.

Parameters:
- STEP_W, 4, width of step count and Z count; maximum steps per job is 2^STEP_W-1.

Ports:
- Clk  input  1  rising-edge clock.
- Rst_n  input  1  asynchronous active-low reset.
- Req0, Req1  input  1 each  job request, held high until the matching Done.
- Seed0, Seed1  input  3 each  initial {Q2,Q1,Q0} for the job.
- A0, A1  input  1 each  serial input A, constant for the whole job.
- Steps0, Steps1  input  STEP_W each  number of shift steps.
- Gnt0, Gnt1  output  1 each  registered grant, high for the whole job.
- Busy  output  1  high in RUN or DONE.
- Done  output  1  one-cycle pulse at end of job.
- DoneId  output  1  requester served: 0 or 1, valid with Done.
- Result  output  3  final {Q2,Q1,Q0}, valid with Done.
- ZCount  output  STEP_W  number of run cycles with Z=1, valid with Done.

Behaviour:
- Reset (async, Rst_n=0): state IDLE; Q=000; Gnt0=Gnt1=Busy=Done=DoneId=0; Result=000; ZCount=0; last_served=1, so Req0 wins the first tie.
- Reset mid-job aborts immediately: grant drops at once, no Done is issued, and captured job data is discarded.
- States: IDLE, RUN, DONE.
- IDLE, no request: hold. Datapath frozen, Z not counted.
- IDLE, request seen at edge e0:
  - Winner is the only requester, or on a tie the one not equal to last_served.
  - Capture winner's Seed into Q, its A into a_r, its Steps into cnt; clear ZCount; set GntN; set DoneId=N; update last_served=N.
  - Next state is RUN if Steps!=0, else DONE.
- RUN, each edge:
  - Shift the datapath using a_r.
  - ZCount += Z, where Z is evaluated on the pre-shift state.
  - cnt -= 1; when cnt==1, next state is DONE.
  - Exactly Steps shifts occur.
- DONE (one cycle): Done=1, Result=Q, ZCount final. Next edge returns to IDLE and clears GntN.
- Latency: Done is high in the cycle after edge e_Steps, i.e. Steps+1 edges after request sampling; Steps=0 gives Done one cycle after grant.
- Back-to-back jobs: a request sampled in the IDLE cycle after DONE gets granted. With both Req held, grants alternate 0,1,0,1.
- Seed, A and Steps changing after e0 have no effect. Req dropping mid-job has no effect; the job completes.
- The non-granted Req is held off with no grant until IDLE.
- Result and ZCount hold their values after Done until the next grant edge.
- ZCount cannot overflow: at most Steps <= 2^STEP_W-1.

Optional Feature:
- Macro: SHIFT_SEQ_ABORT_EN.
- When defined, adds input Abort (1 bit).
  - Abort=1 sampled in RUN: next state is DONE without shifting on that edge; Result and ZCount reflect the steps completed so far.
  - Adds output Aborted (1 bit), high with that Done pulse, reset 0.
  - Abort is ignored in IDLE and DONE.
- When undefined: neither port exists and jobs always run the full Steps.

Test Plan:
- Req0=1, Seed0=000, A0=1, Steps0=4 -> Gnt0 at e0; states 100,010,101,110; Done at cycle 5 with Result=110, ZCount=3, DoneId=0.
- Req1 only, Seed1=000, A1=0, Steps1=2 -> Result=000, ZCount=2, DoneId=1, Gnt0 stays 0.
- Req0 only, Seed0=111, A0=1, Steps0=0 -> Done one cycle after grant, Result=111, ZCount=0; then Steps0=1 -> Result=011, ZCount=0.
- Req0 and Req1 high together from reset, both Steps=1 -> grants Gnt0, Gnt1, Gnt0 in order; never both high at once.
- Rst_n=0 during RUN, Steps0=4 after 2 steps -> Gnt0, Busy and Q clear at once; no Done; after release a new Req1 is served normally.
- With SHIFT_SEQ_ABORT_EN: Seed=000, A=1, Steps=4, Abort pulsed on the 3rd RUN edge -> Done with Aborted=1, Result=010, ZCount=1.
